// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register: valid/ready handshake, optional
// 2-entry skid buffer, flush and bubble insertion for a flat data + control bus.
module pipe_stage_elastic #(
   parameter int DATA_W = 143,
   parameter int CTRL_W = 7,
   parameter bit SKID   = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] data_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic              bubble_i,
   input  logic              flush_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] data_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [1:0]        count_o
);

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL1 = 2'd1,
      FULL2 = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] head_data_q, skid_data_q;
   logic [CTRL_W-1:0] head_ctrl_q, skid_ctrl_q;
   logic [CTRL_W-1:0] in_ctrl;
   logic              accept, emit;
   logic              load_head, load_skid, head_from_skid;

   assign valid_o = (state_q != EMPTY);
   assign count_o = state_q;
   assign data_o  = head_data_q;
   assign ctrl_o  = head_ctrl_q & {CTRL_W{valid_o}};
   assign accept  = valid_i & ready_o;
   assign emit    = valid_o & ready_i;
   assign in_ctrl = bubble_i ? '0 : ctrl_i;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a signal unassigned, which would otherwise infer a latch.
      state_d        = state_q;
      load_head      = 1'b0;
      load_skid      = 1'b0;
      head_from_skid = 1'b0;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d   = FULL1;
               load_head = 1'b1;
            end
         end
         FULL1: begin
            if (accept && emit) begin
               load_head = 1'b1;
            end else if (accept && SKID) begin
               state_d   = FULL2;
               load_skid = 1'b1;
            end else if (emit) begin
               state_d = EMPTY;
            end
         end
         FULL2: begin
            if (emit) begin
               state_d        = FULL1;
               head_from_skid = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Flush discards everything; head payload is left untouched so data_o holds.
      if (flush_i) begin
         state_d        = EMPTY;
         load_head      = 1'b0;
         load_skid      = 1'b0;
         head_from_skid = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= EMPTY;
         head_data_q <= '0;
         head_ctrl_q <= '0;
      end else begin
         state_q <= state_d;
         if (load_head) begin
            head_data_q <= data_i;
            head_ctrl_q <= in_ctrl;
         end else if (head_from_skid) begin
            head_data_q <= skid_data_q;
            head_ctrl_q <= skid_ctrl_q;
         end
      end
   end

   // NOTE: the skid entry is storage only, never observed unless state says it
   // is full, so it is deliberately left without reset.
   always_ff @(posedge clk_i) begin
      if (load_skid) begin
         skid_data_q <= data_i;
         skid_ctrl_q <= in_ctrl;
      end
   end

   generate
      if (SKID) begin : g_skid
         logic ready_q;
         always_ff @(posedge clk_i) begin
            if (rst_i) ready_q <= 1'b1;
            else       ready_q <= (state_d != FULL2);
         end
         assign ready_o = ready_q;
      end else begin : g_noskid
         assign ready_o = !valid_o | ready_i;
      end
   endgenerate

endmodule
